// File: rtl/mem_access.sv
// mem_access -- memory-stage data-bus initiator.
//
// Turns a load/store sitting in M into a single dbus transaction and runs the
// addr_ok/data_ok handshake. The raw 32-bit load word goes to writeback,
// which extracts and sign-extends the byte or halfword itself. This block
// does the store-side alignment: it builds the byte strobes and replicates
// the store data across the word.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   MemReadM     load in M
//   MemWriteM    store in M
//   SizeM        access size (MSIZE1 / MSIZE2 / MSIZE4)
//   ALUOutM      byte address
//   WriteDataM   store source register value
//   FlushM       M-stage instruction squashed
//   StallM       M held by the hazard unit for another reason
//   dreq         bus request {valid, addr, size, strobe, data}
//   dresp        bus response {addr_ok, data_ok, data}
//   ReadDataM    raw load word for writeback
//   MemBusyM     stall request to the hazard unit
//   AdELM/AdESM  misaligned load/store flags (MEM_ALIGN_CHECK_EN builds only)
//
// Build option: define MEM_ALIGN_CHECK_EN to block misaligned half/word
// accesses and report them on AdELM/AdESM instead of issuing them.

package mem_access_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;
endpackage

// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction outstanding; an access present issues this cycle
// ADDR  | valid held with registered fields, waiting for addr_ok
// DATA  | address accepted, waiting for data_ok
// HOLD  | transaction done, M still stalled; serve the captured word
module mem_access
  import mem_access_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       MemReadM,
  input  logic       MemWriteM,
  input  msize_t     SizeM,
  input  addr_t      ALUOutM,
  input  word_t      WriteDataM,
  input  logic       FlushM,
  input  logic       StallM,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output word_t      ReadDataM,
  output logic       MemBusyM
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic       AdELM,
  output logic       AdESM
`endif
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t  stateQ, stateD;

  // Request fields captured on the first valid cycle so the bus sees them
  // stable until addr_ok even if the M-stage inputs wander.
  addr_t   addrQ;
  msize_t  sizeQ;
  strobe_t strobeQ;
  word_t   dataQ;

  word_t   readDataQ;
  logic    discardQ, discardD;

  strobe_t strobeNew;
  word_t   dataNew;
  logic    accessPresent;
  logic    reqValid;
  logic    busy;
  logic    complete;
  logic    dropResult;
  logic    captureEn;
  logic    loadFields;

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    if (SizeM == MSIZE2 && ALUOutM[0])
      misaligned = 1'b1;
    else if (SizeM == MSIZE4 && ALUOutM[1:0] != 2'b00)
      misaligned = 1'b1;
  end

  // Only meaningful while a fresh access would issue; in the other states the
  // M instruction has already been accepted (and so was aligned).
  assign AdELM = (stateQ == IDLE) & MemReadM  & ~FlushM & misaligned;
  assign AdESM = (stateQ == IDLE) & MemWriteM & ~FlushM & misaligned;
  assign accessPresent = (MemReadM | MemWriteM) & ~FlushM & ~misaligned;
`else
  assign accessPresent = (MemReadM | MemWriteM) & ~FlushM;
`endif

  // Store alignment: strobes select the addressed lanes, data is replicated
  // so every lane carries the value and the slave picks by strobe.
  always_comb begin
    strobeNew = 4'b0000;
    dataNew   = WriteDataM;
    case (SizeM)
      MSIZE1: begin
        dataNew = {4{WriteDataM[7:0]}};
        if (MemWriteM) strobeNew = 4'b0001 << ALUOutM[1:0];
      end
      MSIZE2: begin
        dataNew = {2{WriteDataM[15:0]}};
        if (MemWriteM) strobeNew = 4'b0011 << {ALUOutM[1], 1'b0};
      end
      default: begin
        dataNew = WriteDataM;
        if (MemWriteM) strobeNew = 4'b1111;
      end
    endcase
  end

  always_comb begin
    stateD     = stateQ;
    discardD   = discardQ;
    reqValid   = 1'b0;
    busy       = 1'b0;
    complete   = 1'b0;
    loadFields = 1'b0;
    // A flush that lands while the bus owns the transaction cannot cancel it;
    // it only marks the eventual result for discard.
    dropResult = discardQ | FlushM;

    case (stateQ)
      IDLE: begin
        dropResult = 1'b0;
        if (accessPresent) begin
          reqValid   = 1'b1;
          loadFields = 1'b1;
          discardD   = 1'b0;
          if (dresp.addr_ok && dresp.data_ok) begin
            complete = 1'b1;
          end else if (dresp.addr_ok) begin
            stateD = DATA;
            busy   = 1'b1;
          end else begin
            stateD = ADDR;
            busy   = 1'b1;
          end
        end
      end
      ADDR: begin
        reqValid = 1'b1;
        discardD = dropResult;
        if (dresp.addr_ok && dresp.data_ok) begin
          complete = 1'b1;
        end else if (dresp.addr_ok) begin
          stateD = DATA;
          busy   = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
      DATA: begin
        discardD = dropResult;
        if (dresp.data_ok) complete = 1'b1;
        else               busy     = 1'b1;
      end
      HOLD: begin
        if (!StallM) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase

    captureEn = complete & ~dropResult;

    // A discarded result has no instruction waiting for it, so HOLD is skipped.
    if (complete) begin
      discardD = 1'b0;
      stateD   = (captureEn && StallM) ? HOLD : IDLE;
    end

    if (reset) begin
      reqValid = 1'b0;
      busy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      discardQ  <= 1'b0;
      readDataQ <= '0;
      addrQ     <= '0;
      sizeQ     <= MSIZE1;
      strobeQ   <= '0;
      dataQ     <= '0;
    end else begin
      stateQ   <= stateD;
      discardQ <= discardD;
      if (captureEn) readDataQ <= dresp.data;
      if (loadFields) begin
        addrQ   <= ALUOutM;
        sizeQ   <= SizeM;
        strobeQ <= strobeNew;
        dataQ   <= dataNew;
      end
    end
  end

  // In IDLE the live fields go out (zero-bubble issue); elsewhere the
  // registered copy does.
  always_comb begin
    dreq       = '0;
    dreq.valid = reqValid;
    if (stateQ == IDLE) begin
      dreq.addr   = ALUOutM;
      dreq.size   = SizeM;
      dreq.strobe = strobeNew;
      dreq.data   = dataNew;
    end else begin
      dreq.addr   = addrQ;
      dreq.size   = sizeQ;
      dreq.strobe = strobeQ;
      dreq.data   = dataQ;
    end
  end

  assign ReadDataM = captureEn ? dresp.data : readDataQ;
  assign MemBusyM  = busy;

endmodule
